// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared types, glyph constants and blink helper for the
//            multiplexed 7-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef logic [1:0] dig_idx_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] code;
    } snap_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_glyph_0     = 7'h40;
    localparam logic [6:0] c_glyph_1     = 7'h79;
    localparam logic [6:0] c_glyph_2     = 7'h24;
    localparam logic [6:0] c_glyph_3     = 7'h30;
    localparam logic [6:0] c_glyph_4     = 7'h19;
    localparam logic [6:0] c_glyph_5     = 7'h12;
    localparam logic [6:0] c_glyph_6     = 7'h02;
    localparam logic [6:0] c_glyph_7     = 7'h78;
    localparam logic [6:0] c_glyph_dash  = 7'h3F;
    localparam logic [6:0] c_glyph_a     = 7'h08;
    localparam logic [6:0] c_glyph_b     = 7'h03;
    localparam logic [6:0] c_glyph_blank = 7'h7F;

    localparam logic [2:0] c_blink_load  = 3'd4;

    // A fresh change always restarts the blink, even on a half-period edge.
    function automatic logic [2:0] blink_next(input logic       load,
                                              input logic       dec,
                                              input logic [2:0] cur);
        if (load) begin
            return c_blink_load;
        end
        if (dec && (cur != 3'd0)) begin
            return cur - 3'd1;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_encoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_encoder
// Purpose  : Maps a snapshotted {valid, code} plus blink phase to a glyph.
// Revision : 1.0 - initial release
// ============================================================================
module seg_encoder
    import display_pkg::*;
(
    input  logic       valid,
    input  logic [2:0] code,
    input  logic       blank,
    output logic [6:0] glyph
);

    logic [6:0] w_digit;

    always_comb begin
        w_digit = c_glyph_blank;
        case (code)
            3'd0:    w_digit = c_glyph_0;
            3'd1:    w_digit = c_glyph_1;
            3'd2:    w_digit = c_glyph_2;
            3'd3:    w_digit = c_glyph_3;
            3'd4:    w_digit = c_glyph_4;
            3'd5:    w_digit = c_glyph_5;
            3'd6:    w_digit = c_glyph_6;
            default: w_digit = c_glyph_7;
        endcase
    end

    // Blanking wins over the dash so an invalidation blinks like any change
    assign glyph = blank ? c_glyph_blank : (valid ? w_digit : c_glyph_dash);

endmodule
`default_nettype wire

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_driver
// Purpose  : Drives a 4-digit common-anode display "A<code_a>b<code_b>" with
//            per-frame input snapshots and a double blink on code changes.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] code_a,
    input  logic       valid_a,
    input  logic [2:0] code_b,
    input  logic       valid_b,
    output logic [6:0] seg,
    output logic [3:0] dig_en,
    output logic       frame_tick
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = $clog2(BLINK_DIV + 1);

    localparam logic [SLOT_W-1:0]  c_slot_last  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  c_guard      = SLOT_W'(GUARD);
    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]  r_slot_cnt;
    dig_idx_t           r_dig_idx;
    logic [FRAME_W-1:0] r_frame_cnt;
    snap_t              r_snap_a;
    snap_t              r_snap_b;
    logic [2:0]         r_blink_a;
    logic [2:0]         r_blink_b;

    logic               w_slot_wrap;
    logic               w_boundary;
    logic               w_half;
    logic [SLOT_W-1:0]  w_slot_nxt;
    dig_idx_t           w_dig_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    snap_t              w_snap_a_in;
    snap_t              w_snap_b_in;
    snap_t              w_snap_a_nxt;
    snap_t              w_snap_b_nxt;
    logic [2:0]         w_blink_a_nxt;
    logic [2:0]         w_blink_b_nxt;
    logic [6:0]         w_glyph_a;
    logic [6:0]         w_glyph_b;
    logic [6:0]         w_glyph;
    logic               w_dark;
    logic [6:0]         w_seg_nxt;
    logic [3:0]         w_dig_en_nxt;

    assign w_slot_wrap = (r_slot_cnt == c_slot_last);
    assign w_boundary  = w_slot_wrap && (r_dig_idx == 2'd3);
    assign w_half      = w_boundary && (r_frame_cnt == c_frame_last);

    assign w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    assign w_dig_nxt   = w_slot_wrap ? r_dig_idx + 2'd1 : r_dig_idx;
    assign w_frame_nxt = !w_boundary ? r_frame_cnt :
                         (w_half ? '0 : r_frame_cnt + 1'b1);

    assign w_snap_a_in  = '{valid: valid_a, code: code_a};
    assign w_snap_b_in  = '{valid: valid_b, code: code_b};
    assign w_snap_a_nxt = w_boundary ? w_snap_a_in : r_snap_a;
    assign w_snap_b_nxt = w_boundary ? w_snap_b_in : r_snap_b;

    assign w_blink_a_nxt = blink_next(w_boundary && (w_snap_a_in != r_snap_a),
                                      w_half, r_blink_a);
    assign w_blink_b_nxt = blink_next(w_boundary && (w_snap_b_in != r_snap_b),
                                      w_half, r_blink_b);

    // Outputs are built from next-state values so they line up with the slot
    seg_encoder u_enc_a (
        .valid (w_snap_a_nxt.valid),
        .code  (w_snap_a_nxt.code),
        .blank (w_blink_a_nxt[0]),
        .glyph (w_glyph_a)
    );

    seg_encoder u_enc_b (
        .valid (w_snap_b_nxt.valid),
        .code  (w_snap_b_nxt.code),
        .blank (w_blink_b_nxt[0]),
        .glyph (w_glyph_b)
    );

    always_comb begin
        w_glyph = c_glyph_blank;
        case (w_dig_nxt)
            2'd0:    w_glyph = w_glyph_b;
            2'd1:    w_glyph = c_glyph_b;
            2'd2:    w_glyph = w_glyph_a;
            default: w_glyph = c_glyph_a;
        endcase
    end

    assign w_dark       = (w_slot_nxt < c_guard) || !enable;
    assign w_seg_nxt    = w_dark ? c_glyph_blank : w_glyph;
    assign w_dig_en_nxt = w_dark ? 4'hF : ~(4'b0001 << w_dig_nxt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt  <= '0;
            r_dig_idx   <= '0;
            r_frame_cnt <= '0;
            r_snap_a    <= '0;
            r_snap_b    <= '0;
            r_blink_a   <= '0;
            r_blink_b   <= '0;
            seg         <= c_glyph_blank;
            dig_en      <= 4'hF;
            frame_tick  <= 1'b0;
        end else begin
            r_slot_cnt  <= w_slot_nxt;
            r_dig_idx   <= w_dig_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_snap_a    <= w_snap_a_nxt;
            r_snap_b    <= w_snap_b_nxt;
            r_blink_a   <= w_blink_a_nxt;
            r_blink_b   <= w_blink_b_nxt;
            seg         <= w_seg_nxt;
            dig_en      <= w_dig_en_nxt;
            frame_tick  <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_driver
// Purpose  : Directed self-checking bench for display_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

    localparam int SCAN_DIV  = 8;
    localparam int GUARD     = 2;
    localparam int BLINK_DIV = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic [2:0] code_a  = 3'd0;
    logic       valid_a = 1'b0;
    logic [2:0] code_b  = 3'd0;
    logic       valid_b = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int nb     = 0;

    display_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .code_a     (code_a),
        .valid_a    (valid_a),
        .code_b     (code_b),
        .valid_b    (valid_b),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the first cycle of the new frame
    task automatic next_frame;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk("frame_tick_seen", {7'd0, seen}, 8'd1);
        nb++;
    endtask

    // Samples each digit slot at its first post-guard cycle
    task automatic check_frame(input logic [6:0] e0, input logic [6:0] e2);
        step(GUARD);
        chk("d0_seg", seg, e0);
        chk("d0_en", dig_en, 4'hE);
        step(SCAN_DIV);
        chk("d1_seg", seg, 7'h03);
        chk("d1_en", dig_en, 4'hD);
        step(SCAN_DIV);
        chk("d2_seg", seg, e2);
        chk("d2_en", dig_en, 4'hB);
        step(SCAN_DIV);
        chk("d3_seg", seg, 7'h08);
        chk("d3_en", dig_en, 4'h7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] seq5 [10];
        seq5 = '{7'h12, 7'h12, 7'h7F, 7'h7F, 7'h12, 7'h12, 7'h7F, 7'h7F, 7'h12, 7'h12};

        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            code_a  = 3'(i);
            valid_a = i[0];
            code_b  = 3'(~i);
            valid_b = ~i[0];
            chk("rst_seg", seg, 7'h7F);
            chk("rst_en", dig_en, 4'hF);
            chk("rst_tick", frame_tick, 1'b0);
        end
        code_a = 3'd0; valid_a = 1'b0; code_b = 3'd0; valid_b = 1'b0;
        reset_n = 1'b1;

        step(1);
        chk("guard_en", dig_en, 4'hF);
        step(1);
        chk("first_en", dig_en, 4'hE);
        chk("first_seg", seg, 7'h3F);
        for (int k = 3; k <= 32; k++) begin
            step(1);
            chk("first_tick", frame_tick, (k == 32));
        end
        nb = 1;

        check_frame(7'h3F, 7'h3F);
        valid_a = 1'b1; code_a = 3'd2;
        next_frame();                       // frame 2: code 2 loads blink
        check_frame(7'h3F, 7'h24);
        next_frame();                       // frame 3: mid-frame pulse on B
        valid_b = 1'b1;
        step(2);
        chk("pulse_d0", seg, 7'h3F);
        step(3);
        valid_b = 1'b0;
        next_frame(); check_frame(7'h3F, 7'h7F);
        next_frame(); check_frame(7'h3F, 7'h7F);
        next_frame(); check_frame(7'h3F, 7'h24);
        next_frame();
        next_frame(); check_frame(7'h3F, 7'h7F);
        next_frame();
        next_frame(); check_frame(7'h3F, 7'h24);

        next_frame();                       // frame 11: change lands on frame 12
        code_a = 3'd5;
        for (int j = 0; j < 10; j++) begin
            next_frame();
            check_frame(7'h3F, seq5[j]);
        end

        next_frame();                       // frame 22: dark for 3 frames
        enable = 1'b0;
        for (int i = 1; i <= 3 * 32; i++) begin
            step(1);
            chk("dis_en", dig_en, 4'hF);
            chk("dis_seg", seg, 7'h7F);
            chk("dis_tick", frame_tick, ((i % 32) == 0));
        end
        nb += 3;
        step(12);
        chk("reen_before", dig_en, 4'hF);
        enable = 1'b1;
        step(1);
        chk("reen_seg", seg, 7'h03);
        chk("reen_en", dig_en, 4'hD);
        step(7);
        chk("pre_rst_seg", seg, 7'h12);
        chk("pre_rst_en", dig_en, 4'hB);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async_seg", seg, 7'h7F);
        chk("async_en", dig_en, 4'hF);
        chk("async_tick", frame_tick, 1'b0);
        step(3);
        reset_n = 1'b1;
        nb = 0;
        check_frame(7'h3F, 7'h3F);
        next_frame();
        check_frame(7'h3F, 7'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
